cursor_select_ctrl: RTL and testbench

// - Player-input side of the matching game; drives the cursor/selected/selectedCount inputs that vga consumes.
// - Reads vid_mem to resolve selections and match/mismatch.
// - Synchronises and debounces five buttons, moves the cursor over the tile grid, and tracks a selection of up to 2 tiles.
// - Requests a tile clear on a match; on a mismatch, holds the selection visible for a timed interval.

---
 rtl/cursor_select_ctrl_if.sv | 38 +++
 rtl/cursor_select_ctrl.sv | 207 ++++++++++++++++++++
 tb/tb_cursor_select_ctrl.sv | 271 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/cursor_select_ctrl_if.sv
// Bus between the cursor/selection controller and the rest of the matching game.
// master: the controller (drives cursor, selection and clear request).
// slave : the environment (buttons, tile memory, clear writer).
interface cursor_select_ctrl_if #(
  parameter int BITS_PER_BLOCK = 6,
  parameter int BLOCKS_WIDE    = 4,
  parameter int BLOCKS_HIGH    = 2
) ();
  localparam int N  = BLOCKS_WIDE * BLOCKS_HIGH;
  localparam int CW = BLOCKS_WIDE + 1;

  logic                        btn_up;
  logic                        btn_down;
  logic                        btn_left;
  logic                        btn_right;
  logic                        btn_sel;
  logic [BITS_PER_BLOCK*N-1:0] vid_mem;
  logic [CW-1:0]               cursor;
  logic [N-1:0]                selected;
  logic [1:0]                  selectedCount;
  logic                        clear_valid;
  logic [CW-1:0]               clear_idx_a;
  logic [CW-1:0]               clear_idx_b;
  logic                        clear_ready;
  logic                        match_fail;

  modport master (
    input  btn_up, btn_down, btn_left, btn_right, btn_sel, vid_mem, clear_ready,
    output cursor, selected, selectedCount, clear_valid, clear_idx_a, clear_idx_b,
           match_fail
  );

  modport slave (
    output btn_up, btn_down, btn_left, btn_right, btn_sel, vid_mem, clear_ready,
    input  cursor, selected, selectedCount, clear_valid, clear_idx_a, clear_idx_b,
           match_fail
  );
endinterface

// File: rtl/cursor_select_ctrl.sv
// Player-input controller for the tile matching game: button synchronise and
// debounce, cursor movement over the grid, two-tile selection, match/mismatch
// resolution against vid_mem, and the clear handshake.
// Build option: define CURSOR_WRAP_EN to make cursor moves wrap at grid edges;
// without it the cursor stops at the edge.
module cursor_select_ctrl #(
  parameter int BITS_PER_BLOCK  = 6,
  parameter int BLOCKS_WIDE     = 4,
  parameter int BLOCKS_HIGH     = 2,
  parameter int DEBOUNCE_CYCLES = 250000,
  parameter int SHOW_CYCLES     = 25000000
) (
  input logic                 clk,
  input logic                 rst,
  cursor_select_ctrl_if.master bus
);
  localparam int N    = BLOCKS_WIDE * BLOCKS_HIGH;
  localparam int CW   = BLOCKS_WIDE + 1;
  localparam int DB_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int SH_W = (SHOW_CYCLES > 1) ? $clog2(SHOW_CYCLES) : 1;

  localparam int BTN_UP    = 0;
  localparam int BTN_DOWN  = 1;
  localparam int BTN_LEFT  = 2;
  localparam int BTN_RIGHT = 3;
  localparam int BTN_SEL   = 4;

  typedef enum logic [1:0] {IDLE, COMPARE, CLEAR, SHOW} state_t;

  logic [4:0]            btn_raw;
  logic [4:0]            sync_p0;
  logic [4:0]            sync_p1;
  logic [4:0]            db_lvl;
  logic [DB_W-1:0]       db_cnt [5];
  logic [4:0]            press_p2;

  state_t                state;
  logic [CW-1:0]         cursor;
  logic [N-1:0]          selected;
  logic [1:0]            sel_cnt;
  logic                  clear_valid;
  logic [CW-1:0]         clear_idx_a;
  logic [CW-1:0]         clear_idx_b;
  logic                  match_fail;
  logic [SH_W-1:0]       show_cnt;

  logic [CW-1:0]         cur_next;
  int                    row_c;
  int                    col_c;
  logic                  move_any;
  logic                  sel_go;
  logic [N-1:0]          cur_mask;
  logic [BITS_PER_BLOCK-1:0] cur_code;
  logic [CW-1:0]         lo_idx;
  logic [CW-1:0]         hi_idx;
  logic                  lo_found;
  logic [BITS_PER_BLOCK-1:0] code_lo;
  logic [BITS_PER_BLOCK-1:0] code_hi;

  assign btn_raw = {bus.btn_sel, bus.btn_right, bus.btn_left, bus.btn_down, bus.btn_up};

  // Stage p0/p1: two-flop synchroniser; stage p2: debounce and press-edge pulse
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_p0  <= '0;
      sync_p1  <= '0;
      db_lvl   <= '0;
      press_p2 <= '0;
      for (int i = 0; i < 5; i++) db_cnt[i] <= '0;
    end else begin
      sync_p0 <= btn_raw;
      sync_p1 <= sync_p0;
      for (int i = 0; i < 5; i++) begin
        press_p2[i] <= 1'b0;
        if (sync_p1[i] == db_lvl[i]) begin
          db_cnt[i] <= '0;
        end else if (db_cnt[i] == DB_W'(DEBOUNCE_CYCLES - 1)) begin
          db_lvl[i]   <= sync_p1[i];
          db_cnt[i]   <= '0;
          press_p2[i] <= sync_p1[i];
        end else begin
          db_cnt[i] <= db_cnt[i] + 1'b1;
        end
      end
    end
  end

  // Next cursor position from the highest-priority move pulse
  always_comb begin
    cur_next = cursor;
    row_c    = int'(cursor) / BLOCKS_WIDE;
    col_c    = int'(cursor) % BLOCKS_WIDE;
    if (press_p2[BTN_UP]) begin
      if (row_c > 0) cur_next = CW'(int'(cursor) - BLOCKS_WIDE);
`ifdef CURSOR_WRAP_EN
      else cur_next = CW'(int'(cursor) + BLOCKS_WIDE * (BLOCKS_HIGH - 1));
`endif
    end else if (press_p2[BTN_DOWN]) begin
      if (row_c < BLOCKS_HIGH - 1) cur_next = CW'(int'(cursor) + BLOCKS_WIDE);
`ifdef CURSOR_WRAP_EN
      else cur_next = CW'(int'(cursor) - BLOCKS_WIDE * (BLOCKS_HIGH - 1));
`endif
    end else if (press_p2[BTN_LEFT]) begin
      if (col_c > 0) cur_next = CW'(int'(cursor) - 1);
`ifdef CURSOR_WRAP_EN
      else cur_next = CW'(int'(cursor) + BLOCKS_WIDE - 1);
`endif
    end else if (press_p2[BTN_RIGHT]) begin
      if (col_c < BLOCKS_WIDE - 1) cur_next = CW'(int'(cursor) + 1);
`ifdef CURSOR_WRAP_EN
      else cur_next = CW'(int'(cursor) - (BLOCKS_WIDE - 1));
`endif
    end
  end

  assign move_any = |press_p2[BTN_RIGHT:BTN_UP];
  assign sel_go   = press_p2[BTN_SEL] & ~move_any;
  assign cur_mask = N'(1) << cursor;
  assign cur_code = bus.vid_mem[int'(cursor)*BITS_PER_BLOCK +: BITS_PER_BLOCK];

  // Locate the lower and higher selected tile for the compare step
  always_comb begin
    lo_idx   = '0;
    hi_idx   = '0;
    lo_found = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (selected[i]) begin
        if (!lo_found) lo_idx = CW'(i);
        lo_found = 1'b1;
        hi_idx   = CW'(i);
      end
    end
  end

  assign code_lo = bus.vid_mem[int'(lo_idx)*BITS_PER_BLOCK +: BITS_PER_BLOCK];
  assign code_hi = bus.vid_mem[int'(hi_idx)*BITS_PER_BLOCK +: BITS_PER_BLOCK];

  // Cursor register and selection FSM; all outputs registered here
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      cursor      <= '0;
      selected    <= '0;
      sel_cnt     <= '0;
      clear_valid <= 1'b0;
      clear_idx_a <= '0;
      clear_idx_b <= '0;
      match_fail  <= 1'b0;
      show_cnt    <= '0;
    end else begin
      cursor     <= cur_next;
      match_fail <= 1'b0;
      case (state)
        IDLE: begin
          if (sel_go && (cur_code != '0)) begin
            if ((selected & cur_mask) != '0) begin
              selected <= selected & ~cur_mask;
              sel_cnt  <= sel_cnt - 2'd1;
            end else begin
              selected <= selected | cur_mask;
              sel_cnt  <= sel_cnt + 2'd1;
              if (sel_cnt == 2'd1) state <= COMPARE;
            end
          end
        end
        COMPARE: begin
          if (code_lo == code_hi) begin
            clear_idx_a <= lo_idx;
            clear_idx_b <= hi_idx;
            clear_valid <= 1'b1;
            state       <= CLEAR;
          end else begin
            match_fail <= 1'b1;
            show_cnt   <= SH_W'(SHOW_CYCLES - 1);
            state      <= SHOW;
          end
        end
        CLEAR: begin
          if (bus.clear_ready) begin
            clear_valid <= 1'b0;
            selected    <= '0;
            sel_cnt     <= '0;
            state       <= IDLE;
          end
        end
        SHOW: begin
          if (show_cnt == '0) begin
            selected <= '0;
            sel_cnt  <= '0;
            state    <= IDLE;
          end else begin
            show_cnt <= show_cnt - 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.cursor        = cursor;
  assign bus.selected      = selected;
  assign bus.selectedCount = sel_cnt;
  assign bus.clear_valid   = clear_valid;
  assign bus.clear_idx_a   = clear_idx_a;
  assign bus.clear_idx_b   = clear_idx_b;
  assign bus.match_fail    = match_fail;
endmodule

// File: tb/tb_cursor_select_ctrl.sv
// Scoreboard bench for cursor_select_ctrl (4x2 grid, DEBOUNCE_CYCLES=4,
// SHOW_CYCLES=8). Stimulus pushes hand-computed output snapshots with the
// clock cycle they must appear on; a monitor pops one entry every time any
// output changes and compares the full snapshot and its cycle.
module tb_cursor_select_ctrl;
  localparam int BTN_UP    = 0;
  localparam int BTN_DOWN  = 1;
  localparam int BTN_LEFT  = 2;
  localparam int BTN_RIGHT = 3;
  localparam int BTN_SEL   = 4;

  // tile7..tile0 = 1,5,0,9,7,3,5,2
  localparam logic [47:0] VID = {6'd1, 6'd5, 6'd0, 6'd9, 6'd7, 6'd3, 6'd5, 6'd2};

  typedef struct {
    int          cyc;
    logic [26:0] v;
    string       nm;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst;
  logic [4:0] btn;
  logic       crdy;
  int         cyc = 0;
  int         n_chk = 0;
  int         n_fail = 0;
  bit         mon_en = 1'b0;
  exp_t       q[$];

  int          h_cur, h_cnt, h_a, h_b;
  logic [7:0]  h_sel;
  logic        h_cv;

  cursor_select_ctrl_if #(.BITS_PER_BLOCK(6), .BLOCKS_WIDE(4), .BLOCKS_HIGH(2)) bus ();

  cursor_select_ctrl #(
    .BITS_PER_BLOCK(6), .BLOCKS_WIDE(4), .BLOCKS_HIGH(2),
    .DEBOUNCE_CYCLES(4), .SHOW_CYCLES(8)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  assign bus.btn_up      = btn[BTN_UP];
  assign bus.btn_down    = btn[BTN_DOWN];
  assign bus.btn_left    = btn[BTN_LEFT];
  assign bus.btn_right   = btn[BTN_RIGHT];
  assign bus.btn_sel     = btn[BTN_SEL];
  assign bus.vid_mem     = VID;
  assign bus.clear_ready = crdy;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic string fmt(logic [26:0] v);
    return $sformatf("cur=%0d sel=%b cnt=%0d cv=%b a=%0d b=%0d mf=%b",
                     v[26:22], v[21:14], v[13:12], v[11], v[10:6], v[5:1], v[0]);
  endfunction

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push(input string nm, input int at, input int cur, input logic [7:0] s,
                      input int cnt, input logic cv, input int a, input int b, input logic mf);
    exp_t e;
    e.cyc = at;
    e.nm  = nm;
    e.v   = {5'(cur), s, 2'(cnt), cv, 5'(a), 5'(b), mf};
    q.push_back(e);
    h_cur = cur; h_sel = s; h_cnt = cnt; h_cv = cv; h_a = a; h_b = b;
  endtask

  task automatic press(input int b);
    btn[b] = 1'b1;
    tick(10);
    btn[b] = 1'b0;
    tick(10);
  endtask

  // Move press whose cursor result is given by hand; no event if unchanged
  task automatic mv(input int b, input int tgt, input string nm);
    int base;
    base = cyc;
    if (tgt != h_cur) push(nm, base + 7, tgt, h_sel, h_cnt, h_cv, h_a, h_b, 1'b0);
    press(b);
  endtask

  // Select press with hand-computed resulting mask/count; no event if unchanged
  task automatic selp(input logic [7:0] s, input int cnt, input string nm);
    int base;
    base = cyc;
    if (s != h_sel) push(nm, base + 7, h_cur, s, cnt, h_cv, h_a, h_b, 1'b0);
    press(BTN_SEL);
  endtask

  // Monitor: one scoreboard pop per output change
  initial begin
    logic [26:0] snap, prev;
    bit first;
    exp_t e;
    first = 1'b1;
    prev  = '0;
    forever begin
      @(negedge clk);
      if (mon_en) begin
        snap = {bus.cursor, bus.selected, bus.selectedCount, bus.clear_valid,
                bus.clear_idx_a, bus.clear_idx_b, bus.match_fail};
        if (first || snap !== prev) begin
          n_chk++;
          if (q.size() == 0) begin
            n_fail++;
            $display("FAIL unexpected_change: got %s at cycle %0d, required no change",
                     fmt(snap), cyc);
          end else begin
            e = q.pop_front();
            if (e.v !== snap || (e.cyc >= 0 && e.cyc != cyc)) begin
              n_fail++;
              $display("FAIL %s: got %s at cycle %0d, required %s at cycle %0d",
                       e.nm, fmt(snap), cyc, fmt(e.v), e.cyc);
            end
          end
        end
        prev  = snap;
        first = 1'b0;
      end
    end
  end

  initial begin
    int base;
    btn  = '0;
    crdy = 1'b0;
    rst  = 1'b1;
    h_cur = 0; h_sel = '0; h_cnt = 0; h_cv = 1'b0; h_a = 0; h_b = 0;
    tick(3);
    rst = 1'b0;
    push("reset_state", -1, 0, 8'h00, 0, 1'b0, 0, 0, 1'b0);
    mon_en = 1'b1;
    tick(2);

    // 1. Bouncing right button: one move, 7 cycles after the last rising edge
    base = cyc;
    push("bounce_move", base + 8 + 7, 1, 8'h00, 0, 1'b0, 0, 0, 1'b0);
    for (int i = 0; i < 10; i++) begin
      btn[BTN_RIGHT] = (((i / 2) % 2) == 0);
      tick(1);
    end
    tick(10);
    btn[BTN_RIGHT] = 1'b0;
    tick(10);

    // 2. Edge behaviour
    mv(BTN_RIGHT, 2, "right_1_2");
    mv(BTN_RIGHT, 3, "right_2_3");
`ifdef CURSOR_WRAP_EN
    mv(BTN_RIGHT, 0, "right_edge_wrap");
    mv(BTN_UP,    4, "up_edge_wrap");
    mv(BTN_DOWN,  0, "down_edge_wrap");
`else
    mv(BTN_RIGHT, 3, "right_edge_sat");
    mv(BTN_LEFT,  2, "left_3_2");
    mv(BTN_LEFT,  1, "left_2_1");
    mv(BTN_LEFT,  0, "left_1_0");
    mv(BTN_UP,    0, "up_edge_sat");
    mv(BTN_DOWN,  4, "down_0_4");
    mv(BTN_DOWN,  4, "down_edge_sat");
    mv(BTN_UP,    0, "up_4_0");
`endif

    // Simultaneous down+right from tile 0: down wins
    base = cyc;
    push("prio_down_over_right", base + 7, 4, 8'h00, 0, 1'b0, 0, 0, 1'b0);
    btn[BTN_DOWN] = 1'b1; btn[BTN_RIGHT] = 1'b1;
    tick(10);
    btn = '0;
    tick(10);

    // Left+sel together on tile 4: move pulse suppresses the select
    base = cyc;
`ifdef CURSOR_WRAP_EN
    push("left_sel_wrap", base + 7, 7, 8'h00, 0, 1'b0, 0, 0, 1'b0);
`endif
    btn[BTN_LEFT] = 1'b1; btn[BTN_SEL] = 1'b1;
    tick(10);
    btn = '0;
    tick(10);

    // 3. Match on tiles 1 and 6 (code 5); clear_ready while idle is ignored
    crdy = 1'b1;
    tick(3);
    crdy = 1'b0;
`ifdef CURSOR_WRAP_EN
    mv(BTN_LEFT, 6, "goto6_left");
`else
    mv(BTN_RIGHT, 5, "goto5_right");
    mv(BTN_RIGHT, 6, "goto6_right");
`endif
    selp(8'h40, 1, "sel_tile6");
    mv(BTN_UP,   2, "goto2_up");
    mv(BTN_LEFT, 1, "goto1_left");
    base = cyc;
    push("sel_tile1_pair", base + 7, 1, 8'h42, 2, 1'b0, 0, 0, 1'b0);
    push("match_clear_req", base + 8, 1, 8'h42, 2, 1'b1, 1, 6, 1'b0);
    press(BTN_SEL);
    tick(3);
    base = cyc;
    push("clear_handshake", base + 1, 1, 8'h00, 0, 1'b0, 1, 6, 1'b0);
    crdy = 1'b1;
    tick(1);
    crdy = 1'b0;
    tick(5);

    // 4. Mismatch on tiles 0 (code 2) and 2 (code 3); sel during SHOW ignored
    mv(BTN_LEFT, 0, "goto0_left");
    selp(8'h01, 1, "sel_tile0");
    mv(BTN_RIGHT, 1, "goto1_right");
    mv(BTN_RIGHT, 2, "goto2_right");
    base = cyc;
    push("sel_tile2_pair", base + 7,  2, 8'h05, 2, 1'b0, 1, 6, 1'b0);
    push("match_fail_rise", base + 8, 2, 8'h05, 2, 1'b0, 1, 6, 1'b1);
    push("match_fail_fall", base + 9, 2, 8'h05, 2, 1'b0, 1, 6, 1'b0);
    push("show_expire",    base + 16, 2, 8'h00, 0, 1'b0, 1, 6, 1'b0);
    btn[BTN_SEL] = 1'b1; tick(4);
    btn[BTN_SEL] = 1'b0; tick(4);
    btn[BTN_SEL] = 1'b1; tick(4);
    btn[BTN_SEL] = 1'b0; tick(16);

    // 5. Deselect and empty tile, clear_ready held high throughout
    crdy = 1'b1;
    mv(BTN_DOWN, 6, "goto6_down");
    mv(BTN_LEFT, 5, "goto5_left");
    mv(BTN_LEFT, 4, "goto4_left");
    selp(8'h10, 1, "sel_tile4");
    selp(8'h00, 0, "desel_tile4");
    mv(BTN_RIGHT, 5, "goto5_right_b");
    selp(8'h00, 0, "sel_empty_tile5");
    crdy = 1'b0;

    // 6. Reset while a clear is pending
    mv(BTN_RIGHT, 6, "goto6_right_b");
    selp(8'h40, 1, "sel_tile6_b");
    mv(BTN_UP,   2, "goto2_up_b");
    mv(BTN_LEFT, 1, "goto1_left_b");
    base = cyc;
    push("sel_tile1_pair_b", base + 7, 1, 8'h42, 2, 1'b0, 1, 6, 1'b0);
    push("match_clear_req_b", base + 8, 1, 8'h42, 2, 1'b1, 1, 6, 1'b0);
    press(BTN_SEL);
    tick(3);
    base = cyc;
    push("reset_in_clear", base + 1, 0, 8'h00, 0, 1'b0, 0, 0, 1'b0);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    tick(10);

    // Every expected change must have been observed
    n_chk++;
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: got %0d pending entries, required 0 (next %s)",
               q.size(), q[0].nm);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
